// File: rtl/layer3_pkg.sv
// Shared geometry and data types for the layer-3 feature-map pipeline.
package layer3_pkg;
    localparam int L3_IMAGE_WIDTH  = 6;
    localparam int L3_IMAGE_HEIGHT = 8;
    localparam int L3_CHANNELS     = 128;
    localparam int L3_DATA_BITS    = 32;

    localparam int L3_POOL_W = L3_IMAGE_WIDTH / 2;
    localparam int L3_POOL_H = L3_IMAGE_HEIGHT / 2;
    localparam int L3_COL_W  = $clog2(L3_IMAGE_WIDTH);
    localparam int L3_ROW_W  = $clog2(L3_IMAGE_HEIGHT);

    typedef logic signed [L3_DATA_BITS-1:0] ch_vec_t [L3_CHANNELS];
endpackage

// File: rtl/maxpool3_if.sv
// Pixel stream into and pooled pixel stream out of the layer-3 max-pool stage.
interface maxpool3_if;
    import layer3_pkg::*;

    logic    valid_in;
    ch_vec_t data_in;
    logic    valid_out;
    ch_vec_t data_out;
    logic    frame_done;

    modport master (
        output valid_in, data_in,
        input  valid_out, data_out, frame_done
    );

    modport slave (
        input  valid_in, data_in,
        output valid_out, data_out, frame_done
    );
endinterface

// File: rtl/max2_vec.sv
// Per-channel signed maximum of two channel vectors; purely combinational.
module max2_vec
    import layer3_pkg::*;
(
    input  ch_vec_t a,
    input  ch_vec_t b,
    output ch_vec_t y
);
    for (genvar c = 0; c < L3_CHANNELS; c++) begin : g_ch
        assign y[c] = (a[c] > b[c]) ? a[c] : b[c];
    end
endmodule

// File: rtl/maxpool3.sv
// 2x2 / stride-2 signed max-pool over a raster pixel stream, one pooled pixel per window.
// Even-row pair maxima wait in a half-width line buffer for the odd row below them.
module maxpool3
    import layer3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    maxpool3_if.slave  bus
);
    localparam logic [L3_COL_W-1:0] COL_LAST = L3_COL_W'(L3_IMAGE_WIDTH - 1);
    localparam logic [L3_ROW_W-1:0] ROW_LAST = L3_ROW_W'(L3_IMAGE_HEIGHT - 1);

    logic [L3_COL_W-1:0] col;
    logic [L3_ROW_W-1:0] row;
    logic [L3_COL_W-2:0] pcol;
    ch_vec_t             hold;
    ch_vec_t             h_max;
    ch_vec_t             v_max;
    ch_vec_t             up_pair;
    ch_vec_t             data_q;
    ch_vec_t             line_buf [L3_POOL_W];
    logic                win_last;
    logic                last_px;
    logic                out_vld;
    logic                done_q;

    assign pcol     = col[L3_COL_W-1:1];
    assign up_pair  = line_buf[pcol];
    assign last_px  = (col == COL_LAST) && (row == ROW_LAST);
    // Odd column on an odd row is the bottom-right pixel that closes a window.
    assign win_last = bus.valid_in && col[0] && row[0];

    max2_vec u_hmax (.a(hold),    .b(bus.data_in), .y(h_max));
    max2_vec u_vmax (.a(up_pair), .b(h_max),       .y(v_max));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            col     <= '0;
            row     <= '0;
            out_vld <= 1'b0;
            done_q  <= 1'b0;
            hold    <= '{default: '0};
            data_q  <= '{default: '0};
            for (int p = 0; p < L3_POOL_W; p++) begin
                line_buf[p] <= '{default: '0};
            end
        end else begin
            out_vld <= win_last;
            done_q  <= win_last && last_px;
            if (bus.valid_in) begin
                if (!col[0]) begin
                    hold <= bus.data_in;
                end else if (!row[0]) begin
                    line_buf[pcol] <= h_max;
                end
                if (win_last) begin
                    data_q <= v_max;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign bus.valid_out  = out_vld;
    assign bus.data_out   = data_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_maxpool3.sv
// Randomized bench for maxpool3 checked against a frame-level 2x2 max reference.
module tb_maxpool3;
    import layer3_pkg::*;

    typedef logic [L3_CHANNELS*L3_DATA_BITS-1:0] flat_t;
    localparam int NOUT = L3_POOL_W * L3_POOL_H;
    localparam int NPIX = L3_IMAGE_WIDTH * L3_IMAGE_HEIGHT;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    maxpool3_if bus();
    maxpool3 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    int    frame [L3_IMAGE_HEIGHT][L3_IMAGE_WIDTH][L3_CHANNELS];
    flat_t exp_q[$];
    flat_t got_q[$];
    bit    fd_q[$];
    bit    drv_br = 1'b0;
    bit    br_edge = 1'b0;
    int    timing_err = 0;

    // Capture every pooled output and flag valid_out on any cycle that did not close a window.
    always @(posedge clk) br_edge = (rst_n === 1'b0) && (bus.valid_in === 1'b1) && drv_br;
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            got_q.push_back(pack(bus.data_out));
            fd_q.push_back(bus.frame_done);
        end
        if (bus.valid_out !== br_edge) timing_err++;
        if (bus.frame_done === 1'b1 && bus.valid_out !== 1'b1) timing_err++;
    end

    function automatic flat_t pack(input ch_vec_t v);
        flat_t f;
        for (int c = 0; c < L3_CHANNELS; c++) f[c*L3_DATA_BITS +: L3_DATA_BITS] = v[c];
        return f;
    endfunction

    function automatic int diff_ch(input flat_t a, input flat_t b);
        for (int c = 0; c < L3_CHANNELS; c++)
            if (a[c*L3_DATA_BITS +: L3_DATA_BITS] !== b[c*L3_DATA_BITS +: L3_DATA_BITS]) return c;
        return 0;
    endfunction

    function automatic int chv(input flat_t a, input int c);
        return $signed(a[c*L3_DATA_BITS +: L3_DATA_BITS]);
    endfunction

    // Reference: each pooled pixel is the largest of its four source pixels, per channel.
    task automatic model_frame();
        for (int j = 0; j < L3_POOL_H; j++)
            for (int i = 0; i < L3_POOL_W; i++) begin
                flat_t f;
                for (int c = 0; c < L3_CHANNELS; c++) begin
                    int m = frame[2*j][2*i][c];
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++)
                            if (frame[2*j+dy][2*i+dx][c] > m) m = frame[2*j+dy][2*i+dx][c];
                    f[c*L3_DATA_BITS +: L3_DATA_BITS] = m;
                end
                exp_q.push_back(f);
            end
    endtask

    task automatic fill_const(input int v);
        for (int y = 0; y < L3_IMAGE_HEIGHT; y++)
            for (int x = 0; x < L3_IMAGE_WIDTH; x++)
                for (int c = 0; c < L3_CHANNELS; c++) frame[y][x][c] = v;
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < L3_IMAGE_HEIGHT; y++)
            for (int x = 0; x < L3_IMAGE_WIDTH; x++)
                for (int c = 0; c < L3_CHANNELS; c++) frame[y][x][c] = 100*y + 10*x + c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            drv_br = 1'b0;
        end
    endtask

    task automatic send_px(input int x, input int y);
        @(negedge clk);
        bus.valid_in = 1'b1;
        for (int c = 0; c < L3_CHANNELS; c++) bus.data_in[c] = frame[y][x][c];
        drv_br = (x % 2 == 1) && (y % 2 == 1);
    endtask

    task automatic run_frame(input int gap_max, input int npix);
        for (int p = 0; p < npix; p++) begin
            idle($urandom_range(gap_max, 0));
            send_px(p % L3_IMAGE_WIDTH, p / L3_IMAGE_WIDTH);
        end
    endtask

    task automatic clear_capture();
        exp_q.delete();
        got_q.delete();
        fd_q.delete();
        timing_err = 0;
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0;
        bus.data_in = '{default: '0};
        rst_n = 1'b1;
        idle(3);
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out got %b want 0", bus.valid_out); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        n_cmp++; if (pack(bus.data_out) !== '0) begin n_err++; $display("FAIL reset_data_out ch0 got %0d want 0", chv(pack(bus.data_out), 0)); end
        rst_n = 1'b0;
        idle(1);
        clear_capture();
    endtask

    task automatic test_ramp();
        clear_capture();
        fill_ramp();
        model_frame();
        run_frame(0, NPIX);
        idle(3);
        n_cmp++; if (got_q.size() != NOUT) begin n_err++; $display("FAIL ramp_count got %0d want %0d", got_q.size(), NOUT); end
        for (int k = 0; k < got_q.size() && k < NOUT; k++) begin
            int ch = diff_ch(got_q[k], exp_q[k]);
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL ramp_out[%0d] ch%0d got %0d want %0d", k, ch, chv(got_q[k], ch), chv(exp_q[k], ch)); end
            n_cmp++; if (fd_q[k] !== (k == NOUT-1)) begin n_err++; $display("FAIL ramp_frame_done[%0d] got %b want %b", k, fd_q[k], k == NOUT-1); end
        end
        n_cmp++; if (timing_err != 0) begin n_err++; $display("FAIL ramp_timing got %0d stray/missing want 0", timing_err); end
    endtask

    task automatic test_negative();
        clear_capture();
        fill_const(-5);
        for (int j = 0; j < L3_POOL_H; j++)
            for (int i = 0; i < L3_POOL_W; i++) begin
                int r = $urandom_range(3, 0);
                for (int c = 0; c < L3_CHANNELS; c++) frame[2*j + r/2][2*i + r%2][c] = -1;
            end
        model_frame();
        run_frame(0, NPIX);
        idle(3);
        n_cmp++; if (got_q.size() != NOUT) begin n_err++; $display("FAIL neg_count got %0d want %0d", got_q.size(), NOUT); end
        for (int k = 0; k < got_q.size() && k < NOUT; k++) begin
            int ch = diff_ch(got_q[k], exp_q[k]);
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL neg_out[%0d] ch%0d got %0d want %0d", k, ch, chv(got_q[k], ch), chv(exp_q[k], ch)); end
        end
        n_cmp++; if (timing_err != 0) begin n_err++; $display("FAIL neg_timing got %0d want 0", timing_err); end
    endtask

    task automatic test_gaps(input bit random_data);
        clear_capture();
        if (random_data) begin
            for (int y = 0; y < L3_IMAGE_HEIGHT; y++)
                for (int x = 0; x < L3_IMAGE_WIDTH; x++)
                    for (int c = 0; c < L3_CHANNELS; c++) frame[y][x][c] = $urandom;
        end else begin
            fill_ramp();
        end
        model_frame();
        run_frame(3, NPIX);
        idle(3);
        n_cmp++; if (got_q.size() != NOUT) begin n_err++; $display("FAIL gaps%0d_count got %0d want %0d", random_data, got_q.size(), NOUT); end
        for (int k = 0; k < got_q.size() && k < NOUT; k++) begin
            int ch = diff_ch(got_q[k], exp_q[k]);
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL gaps%0d_out[%0d] ch%0d got %0d want %0d", random_data, k, ch, chv(got_q[k], ch), chv(exp_q[k], ch)); end
            n_cmp++; if (fd_q[k] !== (k == NOUT-1)) begin n_err++; $display("FAIL gaps%0d_frame_done[%0d] got %b", random_data, k, fd_q[k]); end
        end
        n_cmp++; if (timing_err != 0) begin n_err++; $display("FAIL gaps%0d_timing got %0d want 0", random_data, timing_err); end
    endtask

    task automatic test_back_to_back();
        int nfd = 0;
        clear_capture();
        fill_const(7);
        model_frame();
        run_frame(0, NPIX);
        fill_const(9);
        model_frame();
        run_frame(0, NPIX);
        idle(3);
        n_cmp++; if (got_q.size() != 2*NOUT) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), 2*NOUT); end
        for (int k = 0; k < got_q.size() && k < 2*NOUT; k++) begin
            int ch = diff_ch(got_q[k], exp_q[k]);
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL b2b_out[%0d] ch%0d got %0d want %0d", k, ch, chv(got_q[k], ch), chv(exp_q[k], ch)); end
            if (fd_q[k]) nfd++;
            n_cmp++; if (fd_q[k] !== (k % NOUT == NOUT-1)) begin n_err++; $display("FAIL b2b_frame_done[%0d] got %b", k, fd_q[k]); end
        end
        n_cmp++; if (nfd != 2) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 2", nfd); end
        n_cmp++; if (timing_err != 0) begin n_err++; $display("FAIL b2b_timing got %0d want 0", timing_err); end
    endtask

    task automatic test_mid_reset();
        clear_capture();
        fill_const(-40);
        run_frame(0, 20);
        @(negedge clk);
        bus.valid_in = 1'b0;
        drv_br = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid_out[%0d] got %b want 0", k, bus.valid_out); end
            n_cmp++; if (pack(bus.data_out) !== '0) begin n_err++; $display("FAIL midrst_data_out[%0d] ch0 got %0d want 0", k, chv(pack(bus.data_out), 0)); end
        end
        rst_n = 1'b0;
        clear_capture();
        idle(4);
        n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL midrst_stray got %0d outputs want 0", got_q.size()); end
        fill_const(3);
        model_frame();
        run_frame(0, NPIX);
        idle(3);
        n_cmp++; if (got_q.size() != NOUT) begin n_err++; $display("FAIL midrst_count got %0d want %0d", got_q.size(), NOUT); end
        for (int k = 0; k < got_q.size() && k < NOUT; k++) begin
            int ch = diff_ch(got_q[k], exp_q[k]);
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL midrst_out[%0d] ch%0d got %0d want %0d", k, ch, chv(got_q[k], ch), chv(exp_q[k], ch)); end
        end
        n_cmp++; if (timing_err != 0) begin n_err++; $display("FAIL midrst_timing got %0d want 0", timing_err); end
    endtask

    task automatic test_channels();
        clear_capture();
        fill_const(1);
        for (int j = 0; j < L3_POOL_H; j++)
            for (int i = 0; i < L3_POOL_W; i++) begin
                frame[2*j][2*i][0] = 1000;
                frame[2*j+1][2*i+1][L3_CHANNELS-1] = 1000;
            end
        model_frame();
        run_frame(1, NPIX);
        idle(3);
        n_cmp++; if (got_q.size() != NOUT) begin n_err++; $display("FAIL chan_count got %0d want %0d", got_q.size(), NOUT); end
        for (int k = 0; k < got_q.size() && k < NOUT; k++) begin
            int ch = diff_ch(got_q[k], exp_q[k]);
            n_cmp++; if (chv(got_q[k], 0) !== 1000) begin n_err++; $display("FAIL chan0[%0d] got %0d want 1000", k, chv(got_q[k], 0)); end
            n_cmp++; if (chv(got_q[k], L3_CHANNELS-1) !== 1000) begin n_err++; $display("FAIL chan127[%0d] got %0d want 1000", k, chv(got_q[k], L3_CHANNELS-1)); end
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL chan_out[%0d] ch%0d got %0d want %0d", k, ch, chv(got_q[k], ch), chv(exp_q[k], ch)); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_gaps(1'b0);
        test_gaps(1'b1);
        test_back_to_back();
        test_mid_reset();
        test_channels();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
